// File: rtl/frame_slot_sequencer_if.sv
// frame_slot_sequencer_if
//   Slot-stream bundle between the frame slot sequencer and its surroundings.
//   i_* signals come from the payload FIFO / line and transmit-record FIFOs;
//   o_* signals are the registered slot stream and the payload pop request.
//   Modports:
//     master : sequencer side (consumes i_*, drives o_*)
//     slave  : environment side (drives i_*, consumes o_*)
interface frame_slot_sequencer_if #(
  parameter int COL_W       = 11,
  parameter int ROW_W       = 2,
  parameter int FRAME_CNT_W = 8
);
  logic                   i_pyld_data_valid;
  logic                   i_line_fifo_ready;
  logic                   i_tran_rec_fifo_ready;
  logic                   i_line_retrans_req;
  logic                   o_data_req;
  logic                   o_slot_valid;
  logic [1:0]             o_slot_type;
  logic [ROW_W-1:0]       o_row_cnt;
  logic [COL_W-1:0]       o_col_cnt;
  logic                   o_sof;
  logic                   o_eof;
  logic [FRAME_CNT_W-1:0] o_frame_cnt;

  modport master (
    input  i_pyld_data_valid, i_line_fifo_ready, i_tran_rec_fifo_ready, i_line_retrans_req,
    output o_data_req, o_slot_valid, o_slot_type, o_row_cnt, o_col_cnt, o_sof, o_eof, o_frame_cnt
  );

  modport slave (
    output i_pyld_data_valid, i_line_fifo_ready, i_tran_rec_fifo_ready, i_line_retrans_req,
    input  o_data_req, o_slot_valid, o_slot_type, o_row_cnt, o_col_cnt, o_sof, o_eof, o_frame_cnt
  );
endinterface

// File: rtl/frame_slot_sequencer.sv
// frame_slot_sequencer
//   Owns the frame row/column counters, classifies each slot as overhead,
//   payload, pad or fill, and issues the payload-FIFO pop request.
//   Ports:
//     i_clk  : clock
//     i_rst  : synchronous active-high reset
//     bus    : frame_slot_sequencer_if.master (FIFO handshakes in, slot stream out)
//   Every output is registered and describes the slot emitted one cycle earlier.
//   Slot type encoding: 0 = OH, 1 = PYLD, 2 = PAD, 3 = FILL.
//   Parameter constraints: OH_COLS >= 1, ROW_LEN - OH_COLS - PAD_COLS >= 1,
//   ROW_LEN <= 2**COL_W, NUM_ROWS <= 2**ROW_W.
module frame_slot_sequencer #(
  parameter int ROW_LEN     = 1041,
  parameter int NUM_ROWS    = 4,
  parameter int OH_COLS     = 16,
  parameter int PAD_COLS    = 1,
  parameter int COL_W       = 11,
  parameter int ROW_W       = 2,
  parameter int FRAME_CNT_W = 8,
  parameter int FILL_MODE   = 0
) (
  input logic                    i_clk,
  input logic                    i_rst,
  frame_slot_sequencer_if.master bus
);

  localparam logic [1:0] SLOT_OH   = 2'd0;
  localparam logic [1:0] SLOT_PYLD = 2'd1;
  localparam logic [1:0] SLOT_PAD  = 2'd2;
  localparam logic [1:0] SLOT_FILL = 2'd3;

  localparam logic [COL_W-1:0] OH_END    = COL_W'(OH_COLS);
  localparam logic [COL_W-1:0] PAD_START = COL_W'(ROW_LEN - PAD_COLS);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic             FILL_EN   = (FILL_MODE != 0);

  // current slot position and completed-frame count
  logic [ROW_W-1:0]       r_row;
  logic [COL_W-1:0]       r_col;
  logic [FRAME_CNT_W-1:0] r_frame;

  // registered output stage
  logic                   r_data_req;
  logic                   r_slot_valid;
  logic [1:0]             r_slot_type;
  logic [ROW_W-1:0]       r_row_cnt;
  logic [COL_W-1:0]       r_col_cnt;
  logic                   r_sof;
  logic                   r_eof;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic       c_is_oh;
  logic       c_is_pad;
  logic       c_is_pyld_col;
  logic       c_gate;
  logic       c_emit;
  logic       c_req;
  logic [1:0] c_type;
  logic       c_last_col;
  logic       c_last_row;
  logic       c_first_slot;

  always_comb begin
    c_is_oh       = (r_col < OH_END);
    c_is_pad      = (r_col >= PAD_START);
    c_is_pyld_col = !c_is_oh && !c_is_pad;
    // retransmission masks everything, including overhead/pad slots
    c_gate        = bus.i_line_fifo_ready && bus.i_tran_rec_fifo_ready && !bus.i_line_retrans_req;
    // a payload column without data only goes out when fill insertion is enabled
    c_emit        = c_gate && (!c_is_pyld_col || bus.i_pyld_data_valid || FILL_EN);
    c_req         = c_emit && c_is_pyld_col && bus.i_pyld_data_valid;
    c_last_col    = (r_col == LAST_COL);
    c_last_row    = (r_row == LAST_ROW);
    c_first_slot  = (r_row == '0) && (r_col == '0);

    c_type = SLOT_OH;
    if (c_is_pad) begin
      c_type = SLOT_PAD;
    end else if (c_is_pyld_col) begin
      c_type = bus.i_pyld_data_valid ? SLOT_PYLD : SLOT_FILL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_frame <= '0;
    end else if (c_emit) begin
      if (c_last_col) begin
        r_col <= '0;
        if (c_last_row) begin
          r_row   <= '0;
          r_frame <= r_frame + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_req   <= 1'b0;
      r_slot_valid <= 1'b0;
      r_slot_type  <= SLOT_OH;
      r_row_cnt    <= '0;
      r_col_cnt    <= '0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_data_req   <= c_req;
      r_slot_valid <= c_emit;
      // SOF/EOF are qualified pulses; type/row/col hold across idle cycles
      r_sof        <= c_emit && c_first_slot;
      r_eof        <= c_emit && c_first_slot == 1'b0 && c_last_col && c_last_row;
      // sampled from r_frame, so the increment shows up one cycle after EOF
      r_frame_cnt  <= r_frame;
      if (c_emit) begin
        r_slot_type <= c_type;
        r_row_cnt   <= r_row;
        r_col_cnt   <= r_col;
      end
    end
  end

  assign bus.o_data_req   = r_data_req;
  assign bus.o_slot_valid = r_slot_valid;
  assign bus.o_slot_type  = r_slot_type;
  assign bus.o_row_cnt    = r_row_cnt;
  assign bus.o_col_cnt    = r_col_cnt;
  assign bus.o_sof        = r_sof;
  assign bus.o_eof        = r_eof;
  assign bus.o_frame_cnt  = r_frame_cnt;

endmodule
